bec_load_sequencer: RTL and testbench
=====================================

Name: bec_load_sequencer

Overview:
Sequencer between the host-side controller logic and the binary-Edwards-curve scalar-multiply core. Host fills 163-bit operand and scalar-key buffers through a 32-bit word-write port, then starts a run. The block answers the core's operand-load requests (trigLoad) and key-bit requests (next_key), then waits for core done and captures the 163-bit result for word-wise readback.

Parameters:
FIELD_W, 163, field element / key width in bits
NUM_OPS, 4, operands loaded per run (indices 0..NUM_OPS-1, max 7)
WORD_W, 32, host word width
TIMEOUT_CYC, 1048576, watchdog limit (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
wr_en  in  1  host word write strobe
wr_addr  in  6  {buf[2:0], word[2:0]}; buf 0..NUM_OPS-1 operands, buf 7 key
wr_data  in  32  write data
start  in  1  one-cycle run request
abort  in  1  one-cycle abort request
rd_word  in  3  result word select
rd_data  out  32  result word (combinational from result register)
busy  out  1  run in progress
run_done  out  1  sticky, set on result capture, cleared by start
err  out  2  sticky error code: 0 none, 1 write-while-busy, 2 key overrun, 3 timeout
core_ena  out  1  core enable
core_load_status  out  3  operand index being loaded
core_data  out  163  operand value to core
core_load_data  out  1  one-cycle load strobe
core_trig_load  in  1  core requests next operand
core_next_key  in  1  core requests next key bit
core_ki  out  1  current key bit
core_result  in  163  core data_out
core_done  in  1  core completion

Behaviour:
- Reset: all outputs 0, buffers and result cleared, state IDLE, bit index FIELD_W-1.
- Word packing: word w holds bits [32w+31:32w]; word 5 uses only bits 2:0 (bits 162:160); writes to words 6-7 and to bufs NUM_OPS..6 are ignored. rd_data for words 6-7 = 0.
- Writes accepted only in IDLE/DONE; while busy they are dropped and err=1.
- States: IDLE, LOAD, RUN, CAPTURE, DONE.
- IDLE/DONE + start (abort low): clear run_done/err, op index=0, bit index=FIELD_W-1, core_ena=1 next cycle, busy=1, -> LOAD.
- LOAD: on core_trig_load, drive core_load_status=idx and core_data=buffer[idx] in the same registered cycle as core_load_data=1 (one-cycle pulse, 1-cycle latency after trig). Level-held trig_load counts once per strobe; the next trig is accepted only after core_load_data deasserts. After index NUM_OPS-1 -> RUN.
- RUN: core_ki always shows key[bit index]. On core_next_key the index decrements in the next cycle (MSB first). A next_key at index 0 leaves core_ki=key[0] and sets an internal exhausted flag. Any further next_key sets err=2; core_ki=0.
- core_done in LOAD or RUN -> CAPTURE. CAPTURE takes one cycle: result<=core_result, run_done=1, core_ena=0, busy=0, -> DONE. DONE behaves as IDLE.
- abort in any busy state: core_ena=0, core_load_data=0, busy=0, -> IDLE next cycle, result unchanged, run_done stays 0. Abort has priority over start, done, trig_load and next_key in the same cycle.
- start while busy is ignored.
- Async reset mid-run returns immediately to the reset values.

Optional Feature:
BEC_SEQ_TIMEOUT_EN: adds a cycle counter, cleared on start and incremented while busy. On reaching TIMEOUT_CYC it acts as an abort and sets err=3. Without the macro there is no counter, err never equals 3, and TIMEOUT_CYC is unused.

Decomposition:
- Package bec_seq_pkg: state enum, FIELD_W, WORD_W, NUM_WORDS=6, KEY_BUF=3'd7, err code constants.
- Sub-module bec_key_shifter: key register, word writes, bit index down-counter, ki mux, exhausted/overrun flag.

Test Plan:
- Write ops 0..3 = 163'h1..163'h4, key = 163'h5_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001; pulse start; core model raises trig_load 4 times -> core_load_status 0,1,2,3 with matching core_data, each core_load_data 1 cycle wide.
- Core pulses next_key 163 times -> core_ki sequence starts 1,0,1 (bits 162..160) and ends 1 (bit 0), err stays 0. A 164th pulse -> err=2.
- core_done with core_result=163'h7_FFFF...F -> one cycle later run_done=1, busy=0; rd_word 0..4 = 32'hFFFF_FFFF, word 5 = 32'h7, word 6 = 0.
- wr_en during RUN -> buffer unchanged, err=1. start during RUN -> no effect.
- abort and core_done asserted in the same cycle during RUN -> IDLE, run_done=0, result unchanged, core_ena=0.
- With BEC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, core never asserts done -> err=3, busy=0 exactly 100 cycles after start.

Source files
------------

// File: rtl/bec_seq_pkg.sv
// Shared constants, state/error codes and word-pack helpers
// for the binary-Edwards-curve load sequencer.
package bec_seq_pkg;

  localparam int FIELD_W   = 163;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 6;
  localparam int IDX_W     = 8;

  localparam logic [2:0] KEY_BUF = 3'd7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_WR_BUSY = 2'd1;
  localparam logic [1:0] ERR_KEY_OVR = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Replace word w of a field element; words past the
  // top of the field (5 upper bits, 6, 7) fall away.
  function automatic logic [FIELD_W-1:0] put_word(
    input logic [FIELD_W-1:0] v,
    input logic [2:0]         w,
    input logic [WORD_W-1:0]  d
  );
    logic [FIELD_W-1:0] r;
    r = v;
    for (int i = 0; i < FIELD_W; i++) begin
      if (i / WORD_W == int'(w)) r[i] = d[i % WORD_W];
    end
    return r;
  endfunction

  // Word w of a field element, zero above bit FIELD_W-1.
  function automatic logic [WORD_W-1:0] get_word(
    input logic [FIELD_W-1:0] v,
    input logic [2:0]         w
  );
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (int'(w) * WORD_W + i < FIELD_W)
        r[i] = v[int'(w) * WORD_W + i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bec_key_shifter.sv
// Scalar-key register with MSB-first bit walk for the BEC core.
// Ports: i_clk, i_rst_n, i_wr_en/i_wr_word/i_wr_data (key word write),
// i_restart (new run), i_step (core next_key), o_ki, o_ovr_hit.
module bec_key_shifter
  import bec_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [2:0]        i_wr_word,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_restart,
  input  logic              i_step,
  output logic              o_ki,
  output logic              o_ovr_hit
);

  logic [FIELD_W-1:0] r_key;
  logic [IDX_W-1:0]   r_bit_idx;
  logic               r_exhausted;
  logic               r_overrun;

  // Once every bit is consumed, ki parks on bit 0 until
  // one more request drives it to 0.
  assign o_ki      = r_overrun ? 1'b0 : r_key[r_bit_idx];
  assign o_ovr_hit = i_step & r_exhausted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key <= '0;
    end else if (i_wr_en) begin
      r_key <= put_word(r_key, i_wr_word, i_wr_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx   <= IDX_W'(FIELD_W - 1);
      r_exhausted <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (i_restart) begin
      r_bit_idx   <= IDX_W'(FIELD_W - 1);
      r_exhausted <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (i_step) begin
      if (r_exhausted) begin
        r_overrun <= 1'b1;
      end else if (r_bit_idx == '0) begin
        r_exhausted <= 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bec_load_sequencer.sv
// Host-side sequencer for the BEC scalar-multiply core: operand/key
// buffers, operand-load handshake, key-bit feed, result capture.
// Ports: wb_clk_i, wb_rst_ni; host wr_en/wr_addr/wr_data, start, abort,
// rd_word/rd_data, busy, run_done, err; core_* handshake to the core.
// Optional watchdog: define BEC_SEQ_TIMEOUT_EN.
module bec_load_sequencer
  import bec_seq_pkg::*;
#(
  parameter int NUM_OPS     = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wr_en,
  input  logic [5:0]         wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         rd_word,
  output logic [WORD_W-1:0]  rd_data,
  output logic               busy,
  output logic               run_done,
  output logic [1:0]         err,
  output logic               core_ena,
  output logic [2:0]         core_load_status,
  output logic [FIELD_W-1:0] core_data,
  output logic               core_load_data,
  input  logic               core_trig_load,
  input  logic               core_next_key,
  output logic               core_ki,
  input  logic [FIELD_W-1:0] core_result,
  input  logic               core_done
);

  logic [2:0]         r_state;
  logic [2:0]         r_idx;
  logic               r_ld;
  logic [2:0]         r_ld_st;
  logic [FIELD_W-1:0] r_core_data;
  logic [FIELD_W-1:0] r_result;
  logic               r_run_done;
  logic [1:0]         r_err;
  logic [FIELD_W-1:0] r_ops [NUM_OPS];

  logic               w_busy;
  logic               w_tmo;
  logic               w_abort;
  logic               w_start;
  logic               w_wr_ok;
  logic               w_wr_bad;
  logic [2:0]         w_buf;
  logic [2:0]         w_word;
  logic               w_trig;
  logic               w_step;
  logic               w_ovr;
  logic               w_ki;
  logic               w_key_we;
  logic               w_last;
  logic [FIELD_W-1:0] w_op_sel;

  assign w_busy = (r_state == S_LOAD) |
                  (r_state == S_RUN)  |
                  (r_state == S_CAPTURE);

  assign w_buf    = wr_addr[5:3];
  assign w_word   = wr_addr[2:0];
  assign w_wr_ok  = wr_en & ~w_busy;
  assign w_wr_bad = wr_en & w_busy;
  assign w_key_we = w_wr_ok & (w_buf == KEY_BUF);

  assign w_abort = w_busy & (abort | w_tmo);
  assign w_start = ~w_busy & start & ~abort;

  // A held trig_load re-arms only after the strobe drops;
  // core_done in the same cycle wins over a load.
  assign w_trig = (r_state == S_LOAD) & core_trig_load &
                  ~r_ld & ~core_done & ~w_abort;
  assign w_step = (r_state == S_RUN) & core_next_key &
                  ~core_done & ~w_abort;
  assign w_last = (r_idx == 3'(NUM_OPS - 1));

  always_comb begin
    w_op_sel = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (r_idx == 3'(i)) w_op_sel = r_ops[i];
    end
  end

`ifdef BEC_SEQ_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_start) begin
      r_tmo_cnt <= '0;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = w_busy & (r_tmo_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign w_tmo        = 1'b0;
`endif

  bec_key_shifter u_key (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_ni),
    .i_wr_en   (w_key_we),
    .i_wr_word (w_word),
    .i_wr_data (wr_data),
    .i_restart (w_start),
    .i_step    (w_step),
    .o_ki      (w_ki),
    .o_ovr_hit (w_ovr)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NUM_OPS; i++) r_ops[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (w_wr_ok && w_buf == 3'(i))
          r_ops[i] <= put_word(r_ops[i], w_word, wr_data);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ld        <= 1'b0;
      r_ld_st     <= '0;
      r_core_data <= '0;
      r_idx       <= '0;
    end else begin
      r_ld <= w_trig;
      if (w_trig) begin
        r_ld_st     <= r_idx;
        r_core_data <= w_op_sel;
        r_idx       <= r_idx + 1'b1;
      end else if (w_start) begin
        r_idx <= '0;
      end
    end
  end

  // Latest error event wins; a new run clears it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_err <= ERR_NONE;
    end else if (w_start) begin
      r_err <= ERR_NONE;
    end else if (w_tmo) begin
      r_err <= ERR_TIMEOUT;
    end else if (w_ovr) begin
      r_err <= ERR_KEY_OVR;
    end else if (w_wr_bad) begin
      r_err <= ERR_WR_BUSY;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_run_done <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state    <= S_LOAD;
            r_run_done <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_abort)                r_state <= S_IDLE;
          else if (core_done)         r_state <= S_CAPTURE;
          else if (w_trig && w_last)  r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_abort)        r_state <= S_IDLE;
          else if (core_done) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_result   <= core_result;
            r_run_done <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = w_busy;
  assign core_ena         = w_busy;
  assign run_done         = r_run_done;
  assign err              = r_err;
  assign core_load_data   = r_ld;
  assign core_load_status = r_ld_st;
  assign core_data        = r_core_data;
  assign core_ki          = w_ki;
  assign rd_data          = get_word(r_result, rd_word);

endmodule

// File: tb/tb_bec_load_sequencer.sv
// Self-checking bench for bec_load_sequencer: directed runs plus
// random traffic against a behavioural model of the sequencer.
module tb_bec_load_sequencer;

  localparam int FW   = 163;
  localparam int NOPS = 4;
`ifdef BEC_SEQ_TIMEOUT_EN
  localparam int TMO = 250;
`else
  localparam int TMO = 1048576;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [5:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    rd_word = '0;
  logic [31:0]   rd_data;
  logic          busy;
  logic          run_done;
  logic [1:0]    err;
  logic          core_ena;
  logic [2:0]    core_load_status;
  logic [FW-1:0] core_data;
  logic          core_load_data;
  logic          core_trig_load = 1'b0;
  logic          core_next_key = 1'b0;
  logic          core_ki;
  logic [FW-1:0] core_result = '0;
  logic          core_done = 1'b0;

  always #5 clk = ~clk;

  bec_load_sequencer #(
    .NUM_OPS     (NOPS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_ni        (rst_n),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .start            (start),
    .abort            (abort),
    .rd_word          (rd_word),
    .rd_data          (rd_data),
    .busy             (busy),
    .run_done         (run_done),
    .err              (err),
    .core_ena         (core_ena),
    .core_load_status (core_load_status),
    .core_data        (core_data),
    .core_load_data   (core_load_data),
    .core_trig_load   (core_trig_load),
    .core_next_key    (core_next_key),
    .core_ki          (core_ki),
    .core_result      (core_result),
    .core_done        (core_done)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [FW-1:0] m_ops [NOPS];
  logic [FW-1:0] m_key, m_result, m_ld_data;
  logic [2:0]    m_ld_st;
  logic [1:0]    m_err;
  bit            m_busy, m_capt, m_ld, m_run_done;
  int            m_loads, m_kpos, m_tmo;

  task automatic m_reset();
    for (int i = 0; i < NOPS; i++) m_ops[i] = '0;
    m_key = '0; m_result = '0; m_ld_data = '0;
    m_ld_st = '0; m_err = '0;
    m_busy = 0; m_capt = 0; m_ld = 0; m_run_done = 0;
    m_loads = 0; m_kpos = 0; m_tmo = 0;
  endtask

  task automatic m_step();
    bit ab, st, trig, step, don, cap, tmo, running;
    int b, w, pos;
    running = m_busy && !m_capt && m_loads == NOPS;
    tmo = 0;
`ifdef BEC_SEQ_TIMEOUT_EN
    tmo = m_busy && (m_tmo == TMO - 1);
`endif
    ab   = m_busy && (abort || tmo);
    st   = !m_busy && start && !abort;
    trig = m_busy && !m_capt && m_loads < NOPS && core_trig_load
           && !m_ld && !core_done && !ab;
    step = running && core_next_key && !core_done && !ab;
    don  = m_busy && !m_capt && core_done && !ab;
    cap  = m_busy && m_capt && !ab;

    if (st)                        m_err = 2'd0;
    else if (tmo)                  m_err = 2'd3;
    else if (step && m_kpos >= FW) m_err = 2'd2;
    else if (wr_en && m_busy)      m_err = 2'd1;

    if (wr_en && !m_busy) begin
      b = int'(wr_addr[5:3]);
      w = int'(wr_addr[2:0]);
      for (int bt = 0; bt < 32; bt++) begin
        pos = 32 * w + bt;
        if (pos < FW) begin
          if (b < NOPS)    m_ops[b][pos] = wr_data[bt];
          else if (b == 7) m_key[pos]    = wr_data[bt];
        end
      end
    end

    m_ld = trig;
    if (trig) begin
      m_ld_st   = 3'(m_loads);
      m_ld_data = m_ops[m_loads];
      m_loads++;
    end
    if (step && m_kpos < 300) m_kpos++;
    if (st) m_tmo = 0;
    else if (m_busy) m_tmo++;

    if (st) begin
      m_busy = 1; m_capt = 0; m_loads = 0; m_kpos = 0; m_run_done = 0;
    end else if (ab) begin
      m_busy = 0; m_capt = 0;
    end else if (cap) begin
      m_result = core_result; m_run_done = 1; m_busy = 0; m_capt = 0;
    end else if (don) begin
      m_capt = 1;
    end
  endtask

  function automatic logic exp_ki();
    if (m_kpos < FW)       return m_key[FW - 1 - m_kpos];
    else if (m_kpos == FW) return m_key[0];
    else                   return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] w);
    logic [31:0] r;
    r = '0;
    for (int bt = 0; bt < 32; bt++) begin
      if (32 * int'(w) + bt < FW) r[bt] = m_result[32 * int'(w) + bt];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("busy", busy, m_busy);
      chk("core_ena", core_ena, m_busy);
      chk("run_done", run_done, m_run_done);
      chk("err", err, m_err);
      chk("load_strobe", core_load_data, m_ld);
      chk("load_status", core_load_status, m_ld_st);
      chk("core_data", core_data, m_ld_data);
      chk("rd_data", rd_data, exp_rd(rd_word));
      if (m_busy && !m_capt && m_loads == NOPS)
        chk("core_ki", core_ki, exp_ki());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic do_load(input int i, input bit lit);
    core_trig_load = 1;
    tick();
    core_trig_load = 0;
    if (lit) begin
      chk("d_ld_strobe", core_load_data, 1'b1);
      chk("d_ld_status", core_load_status, 3'(i));
      chk("d_ld_data", core_data, FW'(i + 1));
    end
    tick();
    if (lit) chk("d_ld_width", core_load_data, 1'b0);
  endtask

  logic kb [FW];
  int   n;
  int   dmod;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ena", core_ena, 1'b0);
    chk("rst_done", run_done, 1'b0);
    chk("rst_err", err, 2'd0);
    chk("rst_ld", core_load_data, 1'b0);
    chk("rst_data", core_data, '0);
    chk("rst_rd", rd_data, 32'd0);
    rst_n = 1;
    chk_on = 1;
    tick();

    for (int i = 0; i < NOPS; i++)
      for (int w = 0; w < 6; w++)
        wr({3'(i), 3'(w)}, (w == 0) ? 32'(i + 1) : 32'd0);
    for (int w = 0; w < 6; w++)
      wr({3'd7, 3'(w)}, (w == 5) ? 32'd5 : (w == 0) ? 32'd1 : 32'd0);

    go();
    chk("d_busy_start", busy, 1'b1);
    for (int i = 0; i < NOPS; i++) do_load(i, 1);

    for (int k = 0; k < FW; k++) begin
      kb[k] = core_ki;
      core_next_key = 1;
      tick();
    end
    core_next_key = 0;
    chk("d_ki_162", kb[0], 1'b1);
    chk("d_ki_161", kb[1], 1'b0);
    chk("d_ki_160", kb[2], 1'b1);
    chk("d_ki_0", kb[FW-1], 1'b1);
    chk("d_err_ok", err, 2'd0);
    core_next_key = 1;
    tick();
    core_next_key = 0;
    chk("d_err_ovr", err, 2'd2);
    chk("d_ki_ovr", core_ki, 1'b0);

    core_result = '1;
    core_done = 1;
    tick();
    core_done = 0;
    chk("d_cap_busy", busy, 1'b1);
    tick();
    chk("d_run_done", run_done, 1'b1);
    chk("d_busy_end", busy, 1'b0);
    chk("d_ena_end", core_ena, 1'b0);
    for (int w = 0; w < 7; w++) begin
      rd_word = 3'(w);
      #1;
      chk("d_rd_word", rd_data,
          (w < 5) ? 32'hFFFF_FFFF : (w == 5) ? 32'h7 : 32'h0);
    end
    rd_word = 0;

    go();
    chk("d_done_clr", run_done, 1'b0);
    chk("d_err_clr", err, 2'd0);
    for (int i = 0; i < NOPS; i++) do_load(i, 0);
    wr(6'o00, 32'hDEAD);
    chk("d_err_wr", err, 2'd1);
    go();
    chk("d_start_busy", busy, 1'b1);
    core_result = '0;
    abort = 1;
    core_done = 1;
    tick();
    abort = 0;
    core_done = 0;
    chk("d_ab_busy", busy, 1'b0);
    chk("d_ab_ena", core_ena, 1'b0);
    chk("d_ab_done", run_done, 1'b0);
    tick();
    chk("d_ab_done2", run_done, 1'b0);
    #1;
    chk("d_ab_result", rd_data, 32'hFFFF_FFFF);

    go();
    core_trig_load = 1;
    tick();
    core_trig_load = 0;
    chk("d_op0_kept", core_data, FW'(1));
    tick();
    #3;
    rst_n = 0;
    #1;
    chk("d_arst_busy", busy, 1'b0);
    chk("d_arst_data", core_data, '0);
    chk("d_arst_rd", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();

`ifdef BEC_SEQ_TIMEOUT_EN
    go();
    n = 0;
    while (busy && n < TMO + 20) begin
      tick();
      n++;
    end
    chk("d_tmo_cycles", 32'(n), 32'(TMO));
    chk("d_tmo_err", err, 2'd3);
`endif

    for (int ph = 0; ph < 2; ph++) begin
      dmod = (ph == 0) ? 120 : 400;
      repeat (3000) begin
        start          = ($urandom % 12) == 0;
        abort          = ($urandom % 150) == 0;
        wr_en          = ($urandom % 6) == 0;
        wr_addr        = 6'($urandom);
        wr_data        = $urandom;
        core_trig_load = 1'($urandom);
        core_next_key  = ($urandom % 4) != 0;
        core_done      = ($urandom % dmod) == 0;
        rd_word        = 3'($urandom);
        if (($urandom % 50) == 0)
          core_result = FW'({$urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom});
        tick();
      end
    end

    start = 0; abort = 0; wr_en = 0;
    core_trig_load = 0; core_next_key = 0; core_done = 0;
    repeat (3) tick();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
